format_ascii: RTL and testbench

FORMAT_ASCII -- requirements
Module: format_ascii

---
 rtl/format_ascii.sv | 128 ++++++++++++
 tb/tb_format_ascii.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/format_ascii.sv
// Formats a signed 16-bit value as decimal ASCII (optional '-', digits, terminator)
// using a sequential double-dabble, then streams characters over a valid/ready handshake.
module format_ascii #(
   parameter logic [7:0] TERM_CHAR = 8'd10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] value,
   output logic        busy,
   output logic [7:0]  ascii,
   output logic        ascii_valid,
   input  logic        ascii_ready
);

   typedef enum logic [2:0] {StIdle, StConv, StSign, StDigit, StTerm} state_e;

   state_e      state_q, state_d;
   logic [19:0] bcd_q, bcd_d;
   logic [15:0] mag_q, mag_d;
   logic        neg_q, neg_d;
   logic [2:0]  idx_q, idx_d;
   logic [4:0]  cnt_q, cnt_d;

   logic [19:0] bcd_adj;
   logic [2:0]  msd;
   logic [3:0]  cur_digit;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Most-significant non-zero digit; falls back to units so zero prints as '0'.
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < 5; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
      end
   end

   always_comb begin
      case (idx_q)
         3'd1:    cur_digit = bcd_q[7:4];
         3'd2:    cur_digit = bcd_q[11:8];
         3'd3:    cur_digit = bcd_q[15:12];
         3'd4:    cur_digit = bcd_q[19:16];
         default: cur_digit = bcd_q[3:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      mag_d   = mag_q;
      neg_d   = neg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               neg_d   = value[15];
               mag_d   = value[15] ? (~value + 16'd1) : value;
               bcd_d   = 20'd0;
               idx_d   = 3'd0;
               cnt_d   = 5'd0;
               state_d = StConv;
            end
         end
         StConv: begin
            // 16 shift cycles, then one cycle to latch the leading-digit index
            if (cnt_q == 5'd16) begin
               idx_d   = msd;
               state_d = neg_q ? StSign : StDigit;
            end else begin
               bcd_d = {bcd_adj[18:0], mag_q[15]};
               mag_d = {mag_q[14:0], 1'b0};
               cnt_d = cnt_q + 5'd1;
            end
         end
         StSign: begin
            if (ascii_ready) state_d = StDigit;
         end
         StDigit: begin
            if (ascii_ready) begin
               if (idx_q == 3'd0) state_d = StTerm;
               else               idx_d   = idx_q - 3'd1;
            end
         end
         StTerm: begin
            if (ascii_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         bcd_q   <= 20'd0;
         mag_q   <= 16'd0;
         neg_q   <= 1'b0;
         idx_q   <= 3'd0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      ascii_valid = (state_q == StSign) || (state_q == StDigit) || (state_q == StTerm);
      case (state_q)
         StSign:  ascii = 8'd45;
         StDigit: ascii = 8'd48 + {4'd0, cur_digit};
         StTerm:  ascii = TERM_CHAR;
         default: ascii = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_format_ascii.sv
// Directed self-checking bench for format_ascii: character streams, latency,
// back-pressure, ignored start while busy, and mid-stream reset.
module tb_format_ascii;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] value;
   logic        busy;
   logic [7:0]  ascii;
   logic        ascii_valid;
   logic        ascii_ready;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  got[8];
   int          ngot;
   int          lat;

   always #5 clk = ~clk;

   format_ascii #(.TERM_CHAR(8'd10)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .value       (value),
      .busy        (busy),
      .ascii       (ascii),
      .ascii_valid (ascii_valid),
      .ascii_ready (ascii_ready)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called on a negedge; start is seen by the next posedge.
   task automatic do_start(input logic [15:0] v);
      start = 1'b1;
      value = v;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid();
      lat = 0;
      while (!ascii_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!ascii_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic collect();
      int guard;
      guard = 0;
      ngot  = 0;
      while (ascii_valid && ngot < 8 && guard < 40) begin
         if (ascii_ready) begin
            got[ngot] = ascii;
            ngot++;
         end
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic check_stream(input string tag, input logic [55:0] e, input int n);
      check({tag, "_len"}, 32'(ngot), 32'(n));
      for (int i = 0; i < n && i < ngot; i++) begin
         check($sformatf("%s_c%0d", tag, i), {24'd0, got[i]}, {24'd0, e[8*(n-1-i) +: 8]});
      end
   endtask

   task automatic run(input string tag, input logic [15:0] v, input logic [55:0] e,
                      input int n);
      do_start(v);
      wait_valid();
      check({tag, "_latency"}, 32'(lat), 32'd17);
      collect();
      check_stream(tag, e, n);
      check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic seen;
      rst         = 1'b1;
      start       = 1'b0;
      value       = 16'd0;
      ascii_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, ascii_valid}, 32'd0);
      check("rst_ascii", {24'd0, ascii}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back runs: each new start lands on the IDLE cycle after TERM.
      run("zero", 16'd0, 56'h300A, 2);
      run("v12345", 16'd12345, 56'h313233_34350A, 6);
      run("neg32768", 16'h8000, 56'h2D333237_36380A, 7);
      run("v100", 16'd100, 56'h3130300A, 4);
      run("v1", 16'd1, 56'h310A, 2);
      run("max", 16'd32767, 56'h33323736370A, 6);

      // Back-pressure on the sign character.
      ascii_ready = 1'b0;
      do_start(16'hFFF9);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("hold_char", {24'd0, ascii}, 32'h2D);
         check("hold_valid", {31'd0, ascii_valid}, 32'd1);
         @(negedge clk);
      end
      ascii_ready = 1'b1;
      collect();
      check_stream("neg7", 56'h2D370A, 3);

      // start held high with another value for the whole conversion and stream.
      do_start(16'd555);
      start = 1'b1;
      value = 16'd9;
      wait_valid();
      collect();
      start = 1'b0;
      check_stream("busy_start", 56'h3535350A, 4);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (ascii_valid || busy) seen = 1'b1;
      end
      check("no_extra_run", {31'd0, seen}, 32'd0);

      // Reset after the second character of 12345.
      do_start(16'd12345);
      wait_valid();
      repeat (2) @(negedge clk);
      check("pre_rst_char", {24'd0, ascii}, 32'h33);
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", {31'd0, ascii_valid}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_ascii", {24'd0, ascii}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (ascii_valid) seen = 1'b1;
      end
      check("rst_no_resume", {31'd0, seen}, 32'd0);
      run("after_rst", 16'd42, 56'h34320A, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
